// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and the memory stage.
// Data accesses win, bounded by a starvation guard; a watchdog aborts stuck transactions.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ack,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              bus_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready
);

    typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    state_t          state;
    logic [SW-1:0]   starve;
    logic [WW-1:0]   wdog;
    logic            mem_pend;
    logic            if_pend;
    logic            grant_mem;
    logic            timeout_hit;

    // A requester seeing its ack this cycle is still holding its line; don't re-grant it.
    always_comb begin
        mem_pend    = (mem_read | mem_write) & ~mem_ack;
        if_pend     = if_req & ~if_ack;
        grant_mem   = mem_pend && !(if_pend && (starve == SW'(STARVE_MAX)));
        timeout_hit = (wdog == WW'(TIMEOUT - 1));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: async reset clears every register, including the bus and data holding
            // registers, so an aborted transaction leaves nothing visible on the outputs.
            state     <= IDLE;
            starve    <= '0;
            wdog      <= '0;
            if_ack    <= 1'b0;
            if_rdata  <= '0;
            mem_ack   <= 1'b0;
            mem_rdata <= '0;
            bus_err   <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            // NOTE: pulse outputs default low here and are overridden below; all state
            // uses non-blocking assignment so every branch sees pre-edge values.
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_mem) begin
                        state     <= MEM_BUSY;
                        ram_en    <= 1'b1;
                        ram_we    <= mem_write;
                        ram_addr  <= mem_addr;
                        ram_wdata <= mem_wdata;
                        wdog      <= '0;
                        if (!if_pend)
                            starve <= '0;
                        else if (starve != SW'(STARVE_MAX))
                            starve <= starve + 1'b1;
                    end else if (if_pend) begin
                        state     <= IF_BUSY;
                        ram_en    <= 1'b1;
                        ram_we    <= 1'b0;
                        ram_addr  <= if_addr;
                        ram_wdata <= '0;
                        wdog      <= '0;
                        starve    <= '0;
                    end
                end
                IF_BUSY, MEM_BUSY: begin
                    if (ram_ready || timeout_hit) begin
                        state   <= IDLE;
                        ram_en  <= 1'b0;
                        ram_we  <= 1'b0;
                        bus_err <= ~ram_ready;
                        if (state == IF_BUSY) begin
                            if_ack   <= 1'b1;
                            if_rdata <= ram_ready ? ram_rdata : '0;
                        end else begin
                            mem_ack   <= 1'b1;
                            mem_rdata <= (ram_ready && !ram_we) ? ram_rdata : '0;
                        end
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by random traffic,
// all compared against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              bus_err;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_ready;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .bus_err(bus_err), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
    );

    always #5 clock = ~clock;

    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    // Reference model: the in-flight transaction as a record plus the expected outputs.
    typedef struct {
        int                who;     // 1 = fetch, 2 = memory stage
        bit                write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                stalled;
    } txn_t;

    bit                busy;
    txn_t              cur;
    int                mem_run;
    bit                e_if_ack, e_mem_ack, e_bus_err, e_ram_en, e_ram_we;
    logic [DATA_W-1:0] e_if_rdata, e_mem_rdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        busy = 0; mem_run = 0; cur = '{0, 0, '0, '0, 0};
        e_if_ack = 0; e_mem_ack = 0; e_bus_err = 0; e_ram_en = 0; e_ram_we = 0;
        e_if_rdata = '0; e_mem_rdata = '0;
    endtask

    task automatic finish_txn(input bit ok);
        busy = 0; e_ram_en = 0; e_ram_we = 0; e_bus_err = !ok;
        if (cur.who == 1) begin
            e_if_ack = 1; e_if_rdata = ok ? ram_rdata : '0;
        end else begin
            e_mem_ack = 1; e_mem_rdata = (ok && !cur.write) ? ram_rdata : '0;
        end
    endtask

    task automatic model_step();
        bit want_if, want_mem;
        if (!reset) return;
        want_if  = if_req && !e_if_ack;
        want_mem = (mem_read || mem_write) && !e_mem_ack;
        e_if_ack = 0; e_mem_ack = 0; e_bus_err = 0;
        if (!busy) begin
            if (want_mem && !(want_if && mem_run >= STARVE_MAX)) begin
                cur = '{2, mem_write, mem_addr, mem_wdata, 0};
                mem_run = want_if ? ((mem_run < STARVE_MAX) ? mem_run + 1 : STARVE_MAX) : 0;
                busy = 1;
            end else if (want_if) begin
                cur = '{1, 1'b0, if_addr, '0, 0};
                mem_run = 0;
                busy = 1;
            end
            if (busy) begin
                e_ram_en = 1; e_ram_we = cur.write;
            end
        end else if (ram_ready) begin
            finish_txn(1);
        end else begin
            cur.stalled++;
            if (cur.stalled == TIMEOUT) finish_txn(0);
        end
    endtask

    task automatic compare();
        check("if_ack", if_ack, e_if_ack);
        check("mem_ack", mem_ack, e_mem_ack);
        check("bus_err", bus_err, e_bus_err);
        check("ram_en", ram_en, e_ram_en);
        check("ram_we", ram_we, e_ram_we);
        if (e_if_ack) check("if_rdata", if_rdata, e_if_rdata);
        if (e_mem_ack) check("mem_rdata", mem_rdata, e_mem_rdata);
        if (e_ram_en) check("ram_addr", ram_addr, cur.addr);
        if (e_ram_we) check("ram_wdata", ram_wdata, cur.wdata);
    endtask

    task automatic check_all_zero();
        check("rst_if_ack", if_ack, 0);
        check("rst_mem_ack", mem_ack, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_mem_rdata", mem_rdata, 0);
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        compare();
    endtask

    // Run until the model expects the given ack; drop that request afterwards.
    task automatic run_to_ack(input int who, input int limit);
        for (int i = 0; i < limit; i++) begin
            tick();
            if (who == 1 && e_if_ack) begin if_req = 0; return; end
            if (who == 2 && e_mem_ack) begin mem_read = 0; mem_write = 0; return; end
        end
        check("ack_budget", 0, 1);
    endtask

    initial begin
        int n;
        reset = 0; if_req = 1; if_addr = 32'h100;
        mem_read = 0; mem_write = 0; mem_addr = '0; mem_wdata = '0;
        ram_ready = 1; ram_rdata = 32'h1111_2222;
        model_reset();

        phase = "reset";
        #1 check_all_zero();
        @(negedge clock) reset = 1;
        tick();
        check("first_grant_addr", ram_addr, 32'h100);
        run_to_ack(1, 10);
        check("first_if_rdata", if_rdata, 32'h1111_2222);
        tick();

        phase = "simultaneous";
        if_req = 1; if_addr = 32'h300; mem_read = 1; mem_addr = 32'h200; ram_rdata = 32'hA5A5_0001;
        tick();
        check("mem_first_addr", ram_addr, 32'h200);
        run_to_ack(2, 10);
        run_to_ack(1, 10);
        check("if_after_mem", if_rdata, 32'hA5A5_0001);
        tick();

        phase = "contention";
        if_req = 1; if_addr = 32'h800; mem_read = 1; mem_addr = 32'h700;
        for (int i = 0; i < 30; i++) begin
            ram_rdata = $urandom;
            tick();
        end
        if_req = 0; mem_read = 0;
        tick(); tick(); tick();

        phase = "store";
        mem_write = 1; mem_addr = 32'h40; mem_wdata = 32'hDEAD_BEEF; ram_ready = 0;
        n = 0;
        for (int i = 0; i < 20 && !e_mem_ack; i++) begin
            tick();
            if (ram_en) n++;
            ram_ready = (n >= 4);
        end
        mem_write = 0;
        check("store_busy_cycles", n, 4);
        check("store_ack", mem_ack, 1);
        check("store_rdata", mem_rdata, 0);
        tick();

        phase = "timeout";
        if_req = 1; if_addr = 32'h500; ram_ready = 0; n = 0;
        for (int i = 0; i < 30 && !e_if_ack; i++) begin
            tick();
            if (ram_en) n++;
        end
        if_req = 0;
        check("timeout_busy_cycles", n, TIMEOUT);
        check("timeout_bus_err", bus_err, 1);
        check("timeout_rdata", if_rdata, 0);
        tick();
        check("bus_err_one_cycle", bus_err, 0);

        phase = "reset_mid";
        mem_read = 1; mem_addr = 32'h600; ram_ready = 0;
        tick(); tick();
        #2 reset = 0;
        #1 check_all_zero();
        model_reset();
        mem_read = 0;
        tick(); tick();
        reset = 1; ram_ready = 1; mem_read = 1; mem_addr = 32'h604; ram_rdata = 32'h0BAD_F00D;
        run_to_ack(2, 10);
        check("resume_rdata", mem_rdata, 32'h0BAD_F00D);

        phase = "random";
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (!if_req || e_if_ack) begin
                if_req = ($urandom_range(0, 2) != 0); if_addr = $urandom;
            end
            if (!(mem_read || mem_write) || e_mem_ack) begin
                int op = $urandom_range(0, 5);
                mem_read = (op == 1 || op == 3 || op == 4); mem_write = (op == 2 || op == 3);
                mem_addr = $urandom; mem_wdata = $urandom;
            end
            if (n > 0) n--;
            else if ($urandom_range(0, 60) == 0) n = $urandom_range(5, 12);
            ram_ready = (n == 0) && ($urandom_range(0, 3) != 0);
            ram_rdata = $urandom;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
